// File: rtl/md_unit_if.sv
// md_unit_if -- operand/result bundle between the EX stage and the
// multiply/divide unit.
//   md_op : operation code (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//           5 MTHI, 6 MTLO, 7 reserved -> NONE)
//   a, b  : forwarded rs / rt operands
//   busy  : mult/div in flight (registered)
//   hi,lo : committed HI / LO registers
interface md_unit_if;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    // EX stage / testbench side
    modport master (output md_op, a, b, input busy, hi, lo);
    // md_unit side
    modport slave  (input md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit -- fixed-latency multiply/divide unit beside the EX stage.
// The result is computed combinationally when an op is accepted, parked in
// pending registers, and committed to HI/LO only when the latency counter
// expires, so software sees MIPS-style multi-cycle timing.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : md_unit_if.slave (md_op, a, b in; busy, hi, lo out)
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_busy,  w_busy_nxt;
    logic          r_wb,    w_wb_nxt;     // commit pending result at completion
    logic [31:0]   r_hi,    w_hi_nxt;
    logic [31:0]   r_lo,    w_lo_nxt;
    logic [31:0]   r_hi_p,  w_hi_p_nxt;
    logic [31:0]   r_lo_p,  w_lo_p_nxt;

    // ---------------- datapath ----------------
    // Multiply: the low 64 bits of the product of the extended operands give
    // the signed or unsigned 64-bit result directly.
    logic [63:0] w_ax, w_bx, w_prod;
    always_comb begin
        w_ax   = {{32{bus.a[31] & (bus.md_op == OP_MULT)}}, bus.a};
        w_bx   = {{32{bus.b[31] & (bus.md_op == OP_MULT)}}, bus.b};
        w_prod = w_ax * w_bx;
    end

    // Divide on magnitudes and re-apply signs afterwards. This sidesteps
    // signed-division corner cases: 0x80000000 / -1 falls out as
    // 2^31 negated = 0x80000000 with remainder 0.
    logic        w_sdiv, w_neg_a, w_neg_b, w_bzero;
    logic [31:0] w_ua, w_ub, w_uq, w_ur, w_q, w_r;
    always_comb begin
        w_sdiv  = (bus.md_op == OP_DIV);
        w_neg_a = w_sdiv & bus.a[31];
        w_neg_b = w_sdiv & bus.b[31];
        w_bzero = (bus.b == 32'd0);
        w_ua    = w_neg_a ? -bus.a : bus.a;
        w_ub    = w_neg_b ? -bus.b : bus.b;
        if (w_bzero) w_ub = 32'd1;   // result is discarded anyway
        w_uq    = w_ua / w_ub;
        w_ur    = w_ua % w_ub;
        w_q     = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
        w_r     = w_neg_a ? -w_ur : w_ur;
    end

    // ---------------- control ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_wb_nxt    = r_wb;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_hi_p_nxt  = r_hi_p;
        w_lo_p_nxt  = r_lo_p;
        case (r_state)
            IDLE: begin
                case (bus.md_op)
                    OP_MULT, OP_MULTU: begin
                        w_hi_p_nxt  = w_prod[63:32];
                        w_lo_p_nxt  = w_prod[31:0];
                        w_wb_nxt    = 1'b1;
                        w_cnt_nxt   = CW'(MULT_CYCLES);
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        w_hi_p_nxt  = w_r;
                        w_lo_p_nxt  = w_q;
                        w_wb_nxt    = ~w_bzero;   // divide by zero leaves HI/LO alone
                        w_cnt_nxt   = CW'(DIV_CYCLES);
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = RUN;
                    end
                    OP_MTHI: w_hi_nxt = bus.a;
                    OP_MTLO: w_lo_nxt = bus.a;
                    default: ;
                endcase
            end
            RUN: begin
                // Any md_op is ignored here.
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    if (r_wb) begin
                        w_hi_nxt = r_hi_p;
                        w_lo_nxt = r_lo_p;
                    end
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_wb    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_hi_p  <= '0;
            r_lo_p  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_wb    <= w_wb_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_hi_p  <= w_hi_p_nxt;
            r_lo_p  <= w_lo_p_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- self-checking bench for md_unit. A longint-arithmetic
// reference model predicts HI/LO and busy duration for each operation.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    md_unit_if bus();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    // Reference model: applies an op to exp_hi/exp_lo, returns busy cycles.
    function automatic int model_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; return 5; end
            3'd2: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; return 5; end
            3'd3: begin
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    exp_lo = q[31:0]; exp_hi = r[31:0];
                end
                return 10;
            end
            3'd4: begin
                if (b != 0) begin
                    up = ua / ub; exp_lo = up[31:0];
                    up = ua % ub; exp_hi = up[31:0];
                end
                return 10;
            end
            3'd5: begin exp_hi = a; return 0; end
            3'd6: begin exp_lo = a; return 0; end
            default: return 0;
        endcase
    endfunction

    // Present op at negedge, accept at posedge, then count cycles busy is
    // high (sampled 1 time unit after each edge). If disturb is set, random
    // ops/operands are driven throughout RUN and hi/lo must stay put.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int n, output bit stable);
        logic [31:0] h0, l0;
        @(negedge clk);
        bus.md_op = op; bus.a = a; bus.b = b;
        h0 = bus.hi; l0 = bus.lo;
        @(posedge clk); #1;
        bus.md_op = 3'd0;
        n = 0;
        stable = 1'b1;
        while (bus.busy === 1'b1 && n < 60) begin
            if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
            if (disturb) begin
                bus.md_op = 3'($urandom_range(1, 7));
                bus.a = $urandom; bus.b = $urandom;
            end
            n++;
            @(posedge clk); #1;
        end
        bus.md_op = 3'd0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset: busy=%b hi=%h lo=%h required 0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        int n, en; bit st;
        en = model_op(3'd1, 32'hFFFFFFFE, 32'd3);
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, n, st);
        checks++;
        if (n !== en || bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA || !st) begin
            failures++;
            $display("FAIL mult: busy=%0d hi=%h lo=%h stable=%b required %0d/ffffffff/fffffffa/1", n, bus.hi, bus.lo, st, en);
        end
        en = model_op(3'd2, 32'hFFFFFFFE, 32'd3);
        run_op(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, n, st);
        checks++;
        if (n !== en || bus.hi !== 32'h00000002 || bus.lo !== 32'hFFFFFFFA) begin
            failures++;
            $display("FAIL multu: busy=%0d hi=%h lo=%h required %0d/00000002/fffffffa", n, bus.hi, bus.lo, en);
        end
    endtask

    task automatic test_div();
        int n, en; bit st;
        en = model_op(3'd3, 32'hFFFFFFF9, 32'd2);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, n, st);
        checks++;
        if (n !== en || bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF || !st) begin
            failures++;
            $display("FAIL div: busy=%0d hi=%h lo=%h required %0d/ffffffff/fffffffd", n, bus.hi, bus.lo, en);
        end
        en = model_op(3'd4, 32'd7, 32'd2);
        run_op(3'd4, 32'd7, 32'd2, 1'b0, n, st);
        checks++;
        if (n !== en || bus.lo !== 32'd3 || bus.hi !== 32'd1) begin
            failures++;
            $display("FAIL divu: busy=%0d hi=%h lo=%h required %0d/1/3", n, bus.hi, bus.lo, en);
        end
    endtask

    task automatic test_mt_divzero();
        int n; bit st;
        void'(model_op(3'd5, 32'h12345678, 32'd0));
        run_op(3'd5, 32'h12345678, 32'd0, 1'b0, n, st);
        checks++;
        if (n !== 0 || bus.hi !== 32'h12345678) begin
            failures++;
            $display("FAIL mthi: busy=%0d hi=%h required 0/12345678", n, bus.hi);
        end
        void'(model_op(3'd6, 32'h9ABCDEF0, 32'd0));
        run_op(3'd6, 32'h9ABCDEF0, 32'd0, 1'b0, n, st);
        checks++;
        if (n !== 0 || bus.lo !== 32'h9ABCDEF0 || bus.hi !== 32'h12345678) begin
            failures++;
            $display("FAIL mtlo: busy=%0d hi=%h lo=%h required 0/12345678/9abcdef0", n, bus.hi, bus.lo);
        end
        void'(model_op(3'd3, 32'd100, 32'd0));
        run_op(3'd3, 32'd100, 32'd0, 1'b0, n, st);
        checks++;
        if (n !== 10 || bus.hi !== 32'h12345678 || bus.lo !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL div_by_zero: busy=%0d hi=%h lo=%h required 10/12345678/9abcdef0", n, bus.hi, bus.lo);
        end
    endtask

    task automatic test_ignore_during_run();
        int n, en; bit st;
        en = model_op(3'd1, 32'd5, 32'd6);
        run_op(3'd1, 32'd5, 32'd6, 1'b1, n, st);
        checks++;
        if (n !== en || bus.hi !== 32'd0 || bus.lo !== 32'd30 || !st) begin
            failures++;
            $display("FAIL ignore_in_run: busy=%0d hi=%h lo=%h stable=%b required %0d/0/1e/1", n, bus.hi, bus.lo, st, en);
        end
        // First idle cycle: run_op presents on the negedge of this same cycle.
        en = model_op(3'd4, 32'd100, 32'd7);
        run_op(3'd4, 32'd100, 32'd7, 1'b0, n, st);
        checks++;
        if (n !== en || bus.lo !== exp_lo || bus.hi !== exp_hi) begin
            failures++;
            $display("FAIL back_to_back: busy=%0d hi=%h lo=%h required %0d/%h/%h", n, bus.hi, bus.lo, en, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset_mid_run();
        int n; bit st;
        run_op(3'd5, 32'hCAFEF00D, 32'd0, 1'b0, n, st);
        @(negedge clk);
        bus.md_op = 3'd3; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.md_op = 3'd0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b hi=%h lo=%h required 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk) reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            failures++;
            $display("FAIL no_wb_after_reset: busy=%b hi=%h lo=%h required 0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_overflow();
        int n, en; bit st;
        en = model_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, n, st);
        checks++;
        if (n !== en || bus.lo !== 32'h80000000 || bus.hi !== 32'd0 || exp_lo !== 32'h80000000) begin
            failures++;
            $display("FAIL overflow: busy=%0d hi=%h lo=%h required %0d/0/80000000", n, bus.hi, bus.lo, en);
        end
    endtask

    task automatic test_random();
        int n, en; bit st;
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            en = model_op(op, a, b);
            run_op(op, a, b, 1'b0, n, st);
            checks++;
            if (n !== en || bus.hi !== exp_hi || bus.lo !== exp_lo || !st) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: busy=%0d hi=%h lo=%h required %0d/%h/%h",
                         i, op, a, b, n, bus.hi, bus.lo, en, exp_hi, exp_lo);
            end
        end
    endtask

    initial begin
        bus.md_op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
        #12 test_reset();
        @(negedge clk) reset = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mt_divzero();
        test_ignore_during_run();
        test_reset_mid_run();
        test_overflow();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the pipelined MIPS core, sitting beside the EX stage. It consumes the forwarded rs/rt operands and the decoded multiply/divide operation, and runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations into HI/LO. It performs MTHI/MTLO writes, exposes HI/LO for MFHI/MFLO, and asserts `busy` so the hazard unit can stall dependent instructions in ID.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high after a multiply is accepted (≥1).
- `DIV_CYCLES`, default 10: cycles `busy` stays high after a divide is accepted (≥1).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `md_op`  in  3: operation from EX: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `a`  in  32: rs operand (forwarded).
- `b`  in  32: rt operand (forwarded).
- `busy`  out  1: registered; high while a mult/div is in flight.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- State: `IDLE` and `RUN`, plus a down-counter `cnt` (4 bits at default parameters; wide enough for max(MULT_CYCLES, DIV_CYCLES)) and pending result registers `hi_p`/`lo_p`.
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0, state = IDLE, `cnt` = 0.
- IDLE, `md_op` 1–4:
  - Compute the result on `a`/`b` as sampled that cycle and latch it into `hi_p`/`lo_p`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES` and go to RUN.
  - `busy` rises after the accepting edge.
- MULT: signed 32×32→64; `hi` = [63:32], `lo` = [31:0].
- MULTU: unsigned 32×32→64; same split as MULT.
- DIV: signed; `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
- DIVU: unsigned; `lo` = quotient, `hi` = remainder.
- Divide by zero (`b` = 0): the operation still takes DIV_CYCLES with `busy` high, but `hi`/`lo` are left unchanged at completion.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- IDLE, MTHI: `hi` ← `a` on that edge; no `busy`.
- IDLE, MTLO: `lo` ← `a` on that edge; no `busy`.
- RUN:
  - `cnt` decrements every cycle.
  - On the edge where `cnt` goes 1→0: `hi`/`lo` ← `hi_p`/`lo_p`, `busy` falls, state returns to IDLE.
- Any `md_op` ≠ 0 presented while `busy` = 1 is ignored: no restart, no HI/LO write. The hazard unit guarantees this never happens architecturally; the unit stays safe regardless.
- `hi`/`lo` show committed values only. The pending result is never visible early.

## Timing
- A mult/div accepted at edge T gives `busy` = 1 from T until edge T+N, where N = MULT_CYCLES or DIV_CYCLES.
- New `hi`/`lo` are visible after edge T+N, and `busy` = 0 after that same edge.
- A new op may be presented in the cycle right after `busy` falls, i.e. accepted at edge T+N+1. Back-to-back operations have no dead cycle beyond this.
- MTHI/MTLO: value visible the cycle after the accepting edge; latency 1.
- Reset asserted mid-RUN: `busy`, `hi`, `lo` clear to 0 immediately without waiting for a clock edge. The pending result is discarded. After reset deasserts, the unit is IDLE.
- Operands sampled only at the accepting edge. Changes to `a`/`b` during RUN have no effect.

## Test plan
- Reset, then MULT with a=0xFFFFFFFE (−2), b=3: `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat as MULTU with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- DIV with a=0xFFFFFFF9 (−7), b=2: `busy` 10 cycles; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU with a=7, b=2: lo=3, hi=1.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on the next cycle: hi/lo update 1 cycle after each, and `busy` never asserts. Then DIV with b=0: `busy` 10 cycles, and hi/lo still read 0x12345678/0x9ABCDEF0.
- Start MULT (a=5, b=6), change `a`/`b` and drive MTLO plus a DIVU during RUN: all ignored; final hi=0, lo=30. Then a DIVU in the first idle cycle is accepted.
- Start DIV, assert `reset` asynchronously at cycle 4 of RUN (between clock edges): `busy`/`hi`/`lo` go 0 before the next edge, and no write-back occurs after release.
- Overflow case, a=0x80000000, b=0xFFFFFFFF, DIV: lo=0x80000000, hi=0, and the unit must not hang.
